// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the rv32 IF stage.
//   - Fetch-controller state encoding (PCF_BOOT / PCF_REQ / PCF_HOLD).
//   - Default address width and reset vector used by pc_fetch_ctrl.
// No ports; imported with `import rv32_pkg::*;`.
package rv32_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Fetch controller states (two bits, legacy-compatible constants).
  localparam logic [1:0] PCF_BOOT = 2'd0;  // one idle cycle after reset
  localparam logic [1:0] PCF_REQ  = 2'd1;  // request presented to imem
  localparam logic [1:0] PCF_HOLD = 2'd2;  // no request (hazard stall)

endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch program-counter controller for the rv32 IF stage.
//
// Owns the architectural fetch PC and presents it to instruction memory over a
// valid/ready handshake. Honours hazard stalls, absorbs EX redirects (also
// while a request waits for ready), and marks accepted fetches that a
// redirect has made wrong-path.
//
// Parameters:
//   XLEN         address / PC width
//   RESET_VECTOR PC after reset (aligned to ILEN_BYTES)
//   ILEN_BYTES   sequential step in bytes (power of two)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hazard hold, blocks issue of a new request
//   redir_valid/target  one-cycle redirect strobe and destination
//   imem_req_valid/ready, imem_addr   fetch request handshake
//   pc, pc_nxt          registered fetch PC and pc + ILEN_BYTES
//   fetch_fire          request accepted this cycle
//   fetch_kill          accepted fetch is wrong-path
//   misalign_err        sticky misaligned-redirect flag
//
// Build option: define PC_ALIGN_CHECK_EN to reject misaligned redirects and
// report them on misalign_err; otherwise redirect targets are silently
// aligned down and misalign_err is tied low.
module pc_fetch_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int unsigned     ILEN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_nxt,
  output logic            fetch_fire,
  output logic            fetch_kill,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ILEN_BYTES - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(ILEN_BYTES);

  logic [1:0]      r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic            r_pend, w_pend_next;
  logic [XLEN-1:0] r_pend_target, w_pend_target_next;

  // Redirect as seen by the rest of the logic: w_redir_ok says whether it is
  // applied at all, w_redir_tgt is the (aligned) address to use.
  logic            w_redir_ok;
  logic [XLEN-1:0] w_redir_tgt;

`ifdef PC_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misalign_err;

  assign w_misaligned = |(redir_target & LOW_MASK);
  assign w_redir_ok   = redir_valid & ~w_misaligned;
  assign w_redir_tgt  = redir_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (redir_valid && w_misaligned) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_redir_ok   = redir_valid;
  assign w_redir_tgt  = redir_target & ~LOW_MASK;
  assign misalign_err = 1'b0;
`endif

  // Valid is masked during reset so no fetch is accepted in the cycle a
  // request is abandoned.
  assign imem_req_valid = (r_state == PCF_REQ) && !rst;
  assign fetch_fire     = imem_req_valid & imem_req_ready;
  assign fetch_kill     = fetch_fire & (r_pend | w_redir_ok);
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign pc_nxt         = r_pc + STEP;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_pend_next        = r_pend;
    w_pend_target_next = r_pend_target;

    case (r_state)
      PCF_REQ: begin
        if (fetch_fire) begin
          // A redirect arriving with the fire is newer than any pending one.
          if (w_redir_ok) begin
            w_pc_next = w_redir_tgt;
          end else if (r_pend) begin
            w_pc_next = r_pend_target;
          end else begin
            w_pc_next = pc_nxt;
          end
          w_pend_next  = 1'b0;
          w_state_next = stall ? PCF_HOLD : PCF_REQ;
        end else if (w_redir_ok) begin
          // Address must stay stable until accepted; park the redirect.
          w_pend_next        = 1'b1;
          w_pend_target_next = w_redir_tgt;
        end
      end
      default: begin
        // BOOT and HOLD: nothing outstanding, so a redirect lands on pc
        // directly. An unused encoding recovers the same way.
        if (w_redir_ok) begin
          w_pc_next = w_redir_tgt;
        end
        w_state_next = stall ? PCF_HOLD : PCF_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= PCF_BOOT;
      r_pc          <= RESET_VECTOR;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pend        <= w_pend_next;
      r_pend_target <= w_pend_target_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: self-checking bench for pc_fetch_ctrl.
// Directed scenarios followed by randomized stimulus, all compared each
// cycle against a behavioural model of the fetch PC (PC value, "requesting"
// flag and a queue of parked redirect targets).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        fetch_fire;
  logic        fetch_kill;
  logic        misalign_err;

  pc_fetch_ctrl #(
    .XLEN        (32),
    .RESET_VECTOR(RV),
    .ILEN_BYTES  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .pc_nxt        (pc_nxt),
    .fetch_fire    (fetch_fire),
    .fetch_kill    (fetch_kill),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model.
  logic [31:0] m_pc;
  bit          m_req;      // a request is being presented
  bit          m_err;
  bit          m_known = 1'b0;
  logic [31:0] m_pendq[$]; // redirects parked while waiting for ready

  // Last observed outputs, for directed spot checks.
  logic [31:0] obs_addr;
  logic        obs_valid, obs_fire, obs_kill, obs_err;
  logic [31:0] obs_nxt;
  bit          verbose = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] t, input logic rd);
    bit          eff;
    logic [31:0] et;
    bit          e_valid, e_fire, e_kill;
    @(negedge clk);
    rst = r; stall = s; redir_valid = rv; redir_target = t; imem_req_ready = rd;
    #1;
    eff     = rv && (!ALIGN_CHK || (t % 4 == 0));
    et      = ALIGN_CHK ? t : (t & ~32'd3);
    e_valid = m_req && !r;
    e_fire  = e_valid && rd;
    e_kill  = e_fire && (m_pendq.size() > 0 || eff);
    obs_addr = imem_addr; obs_valid = imem_req_valid; obs_fire = fetch_fire;
    obs_kill = fetch_kill; obs_err = misalign_err; obs_nxt = pc_nxt;
    if (m_known) begin
      check("valid",   {31'd0, imem_req_valid}, {31'd0, e_valid});
      check("addr",    imem_addr, m_pc);
      check("pc",      pc, m_pc);
      check("pc_nxt",  pc_nxt, m_pc + 32'd4);
      check("fire",    {31'd0, fetch_fire}, {31'd0, e_fire});
      check("kill",    {31'd0, fetch_kill}, {31'd0, e_kill});
      check("misalign",{31'd0, misalign_err}, {31'd0, m_err});
    end
    if (verbose)
      $display("[TB] rst=%0b stall=%0b redir=%0b tgt=%h ready=%0b | valid=%0b addr=%h fire=%0b kill=%0b err=%0b",
               r, s, rv, t, rd, imem_req_valid, imem_addr, fetch_fire, fetch_kill, misalign_err);
    @(posedge clk);
    if (r) begin
      m_pc = RV; m_req = 1'b0; m_err = 1'b0; m_pendq.delete(); m_known = 1'b1;
    end else begin
      if (ALIGN_CHK && rv && (t % 4 != 0)) m_err = 1'b1;
      if (!m_req) begin
        if (eff) m_pc = et;
        m_req = !s;
      end else if (e_fire) begin
        if (eff)                     m_pc = et;
        else if (m_pendq.size() > 0) m_pc = m_pendq[$];
        else                         m_pc = m_pc + 32'd4;
        m_pendq.delete();
        m_req = !s;
      end else if (eff) begin
        m_pendq.push_back(et);
      end
    end
  endtask

  initial begin
    // Reset, then sequential fetch from the reset vector.
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1); check("boot_valid", {31'd0, obs_valid}, 32'd0);
    step(0, 0, 0, 0, 1); check("seq0", obs_addr, 32'h100); check("seq0_kill", {31'd0, obs_kill}, 32'd0);
    step(0, 0, 0, 0, 1); check("seq1", obs_addr, 32'h104);
    step(0, 0, 0, 0, 1); check("seq2", obs_addr, 32'h108); check("seq2_fire", {31'd0, obs_fire}, 32'd1);

    // Redirects while waiting for ready: newest wins, address stays put.
    step(0, 0, 1, 32'h200, 1);
    step(0, 0, 1, 32'h400, 0); check("hold_addr1", obs_addr, 32'h200);
    step(0, 0, 1, 32'h500, 0); check("hold_addr2", obs_addr, 32'h200);
    step(0, 0, 0, 0, 0);       check("hold_addr3", obs_addr, 32'h200);
    step(0, 0, 0, 0, 1);       check("pend_kill", {31'd0, obs_kill}, 32'd1);
    step(0, 0, 0, 0, 1);       check("pend_tgt", obs_addr, 32'h500);

    // Stall at fire, redirect during HOLD.
    step(0, 0, 1, 32'h10, 1);
    step(0, 1, 0, 0, 1);       check("stall_fire", obs_addr, 32'h10);
    step(0, 1, 1, 32'h80, 1);  check("hold_novalid", {31'd0, obs_valid}, 32'd0);
    step(0, 0, 0, 0, 1);       check("hold_novalid2", {31'd0, obs_valid}, 32'd0);
    step(0, 0, 0, 0, 1);       check("hold_redir", obs_addr, 32'h80);

    // Redirect in the same cycle as fire.
    step(0, 0, 1, 32'h20, 1);
    step(0, 0, 1, 32'h300, 1); check("same_addr", obs_addr, 32'h20); check("same_kill", {31'd0, obs_kill}, 32'd1);
    step(0, 0, 0, 0, 1);       check("same_tgt", obs_addr, 32'h300);

    // Wrap-around at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 1);       check("wrap_addr", obs_addr, 32'hFFFF_FFFC); check("wrap_nxt", obs_nxt, 32'h0);
    step(0, 0, 0, 0, 1);       check("wrap_pc", obs_addr, 32'h0);

    // Misaligned redirect.
    step(0, 0, 1, 32'h302, 1);
    step(0, 0, 0, 0, 1);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_addr", obs_addr, 32'h8);
    check("mis_err", {31'd0, obs_err}, 32'd1);
`else
    check("mis_addr", obs_addr, 32'h300);
    check("mis_err", {31'd0, obs_err}, 32'd0);
`endif

    // Reset while a request waits on ready, with a redirect that is dropped.
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h700, 0);
    step(0, 0, 0, 0, 1);       check("rst_valid", {31'd0, obs_valid}, 32'd0); check("rst_pc", obs_addr, RV);
    step(0, 0, 0, 0, 1);       check("rst_fetch", obs_addr, RV); check("rst_kill", {31'd0, obs_kill}, 32'd0);
    check("rst_err", {31'd0, obs_err}, 32'd0);

    // Randomized traffic.
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(7) != 0) t = t & ~32'd3;
      step($urandom_range(99) == 0, $urandom_range(3) == 0,
           $urandom_range(3) == 0, t, $urandom_range(2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
